// File: rtl/reflet_pwm_multi.sv
// Multi-channel PWM: shared prescaled up/edge or up-down/center counter, per-channel compare, shadowed config.
// Latency: counter value drives out one clk later; update_ack/period_start pulse one clk after the boundary load.
// Backpressure: none; update requests are latched as pending and absorbed until the next period boundary.
module reflet_pwm_multi #(
   parameter int WIDTH           = 8,
   parameter int CHANNELS        = 4,
   parameter int PRESCALER_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [PRESCALER_WIDTH-1:0] prescaler,
   input  logic [WIDTH-1:0]          max,
   input  logic                      center_mode,
   input  logic [CHANNELS*WIDTH-1:0] duty_cycle,
   input  logic [CHANNELS-1:0]       invert,
   input  logic                      update,
   output logic                      update_ack,
   output logic                      period_start,
   output logic [CHANNELS-1:0]       out
);

   logic [PRESCALER_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
   logic [WIDTH-1:0]           cnt_q, cnt_d;
   logic                       dir_q, dir_d;       // 0 = counting up, 1 = counting down
   logic [WIDTH-1:0]           max_a_q;
   logic                       center_a_q;
   logic [CHANNELS*WIDTH-1:0]  duty_a_q;
   logic                       pending_q, pending_d;
   logic [CHANNELS-1:0]        out_q, out_d;
   logic                       ack_q;
   logic                       ps_q, ps_d;
   logic                       en_q;               // enable seen at the previous edge
   logic                       start_q;            // counter wrapped to 0 at the previous edge
   logic                       load_q;             // active registers loaded at the previous edge
   logic                       tick;
   logic                       boundary;
   logic                       load;
   logic [CHANNELS-1:0]        raw;

   // Next-state for prescaler, counter, shadow load and output levels
   always_comb begin
      tick      = enable && (pre_cnt_q >= prescaler);
      pre_cnt_d = '0;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      boundary  = 1'b0;
      raw       = '0;

      if (enable && !tick)
         pre_cnt_d = pre_cnt_q + 1'b1;

      if (!enable) begin
         cnt_d = '0;
         dir_d = 1'b0;
      end else if (tick) begin
         if (max_a_q == '0) begin
            // Degenerate period: every tick is a period boundary so pending loads still happen
            cnt_d    = '0;
            boundary = 1'b1;
         end else if (!center_a_q) begin
            if (({1'b0, cnt_q} + 1'b1) >= {1'b0, max_a_q}) begin
               cnt_d    = '0;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (dir_q || (cnt_q >= max_a_q)) begin
               cnt_d = cnt_q - 1'b1;
               dir_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            // Reaching 0 on the way down closes the period and turns the counter back up
            if (dir_d && (cnt_d == '0)) begin
               dir_d    = 1'b0;
               boundary = 1'b1;
            end
         end
      end

      load      = (pending_q || update) && (boundary || !enable);
      pending_d = (pending_q || update) && !load;
      if (load) begin
         cnt_d = '0;
         dir_d = 1'b0;
      end

      for (int n = 0; n < CHANNELS; n++)
         raw[n] = cnt_q < duty_a_q[n*WIDTH +: WIDTH];

      out_d = enable ? (raw ^ invert) : invert;
      ps_d  = enable && (start_q || !en_q);
   end

   // State registers and registered outputs, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_q  <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         max_a_q    <= '0;
         center_a_q <= 1'b0;
         duty_a_q   <= '0;
         pending_q  <= 1'b0;
         out_q      <= '0;
         ack_q      <= 1'b0;
         ps_q       <= 1'b0;
         en_q       <= 1'b0;
         start_q    <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         ps_q      <= ps_d;
         en_q      <= enable;
         start_q   <= enable && boundary;
         load_q    <= load;
         ack_q     <= load_q;
         if (load) begin
            max_a_q    <= max;
            center_a_q <= center_mode;
            duty_a_q   <= duty_cycle;
         end
      end
   end

   assign out          = out_q;
   assign update_ack   = ack_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_reflet_pwm_multi.sv
// Self-checking bench for reflet_pwm_multi: directed scenarios plus randomized configs against a phase-based model.
// Latency: model predicts registered outputs one edge after the inputs it samples.
// Backpressure: n/a; update is driven as single-cycle pulses.
module tb_reflet_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [7:0]      psc = '0;
    logic [W-1:0]    max_v = '0;
    logic            center = 1'b0;
    logic [CH*W-1:0] duty = '0;
    logic [CH-1:0]   inv = '0;
    logic            upd = 1'b0;
    logic            ack;
    logic            ps;
    logic [CH-1:0]   pwm;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position in the period is tracked as a tick phase, the counter is derived from it
    int          m_pre, m_phase, m_max;
    bit          m_center;
    int          m_duty [CH];
    bit          m_pend, m_wrap, m_loaded, m_en_prev;
    logic [CH-1:0] e_out;
    logic        e_ps, e_ack;

    reflet_pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALER_WIDTH(8)) dut (
        .clk(clk), .reset(rst), .enable(en), .prescaler(psc), .max(max_v),
        .center_mode(center), .duty_cycle(duty), .invert(inv), .update(upd),
        .update_ack(ack), .period_start(ps), .out(pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int cnt_of(input int ph);
        if (m_center && ph > m_max) return 2 * m_max - ph;
        return ph;
    endfunction

    task automatic model_reset();
        m_pre = 0; m_phase = 0; m_max = 0; m_center = 0;
        for (int n = 0; n < CH; n++) m_duty[n] = 0;
        m_pend = 0; m_wrap = 0; m_loaded = 0; m_en_prev = 0;
    endtask

    task automatic model_step();
        bit tick, bnd, ld;
        int len, c;
        c = cnt_of(m_phase);
        for (int n = 0; n < CH; n++)
            e_out[n] = en ? ((c < m_duty[n]) ^ inv[n]) : inv[n];
        e_ps  = en && (m_wrap || !m_en_prev);
        e_ack = m_loaded;
        bnd = 0;
        if (!en) begin
            m_pre = 0; m_phase = 0;
        end else begin
            tick  = (m_pre >= int'(psc));
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                len = (m_max == 0) ? 1 : (m_center ? 2 * m_max : m_max);
                if (m_phase + 1 >= len) begin
                    m_phase = 0; bnd = 1;
                end else begin
                    m_phase++;
                end
            end
        end
        ld = (m_pend || upd) && (!en || bnd);
        if (ld) begin
            m_max = int'(max_v); m_center = center; m_phase = 0;
            for (int n = 0; n < CH; n++) m_duty[n] = int'(duty[n*W +: W]);
        end
        m_pend = (m_pend || upd) && !ld;
        m_wrap = en && bnd; m_loaded = ld; m_en_prev = en;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("out", 32'(pwm), 32'(e_out));
            check("period_start", 32'(ps), 32'(e_ps));
            check("update_ack", 32'(ack), 32'(e_ack));
            upd = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out", 32'(pwm), 32'd0);
        check("rst_ps", 32'(ps), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        model_reset();
        upd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int p, input int mx, input int d0, input int d1, input bit cm, input logic [1:0] iv);
        psc = 8'(p); max_v = 8'(mx); center = cm; inv = iv;
        duty = {8'(d1), 8'(d0)};
    endtask

    initial begin
        model_reset();
        do_reset();
        // Edge mode, loaded while disabled, then enabled
        set_cfg(0, 10, 3, 0, 0, 2'b00);
        run(2);
        upd = 1'b1;
        run(3);
        en = 1'b1;
        run(25);
        // Duty at and above max
        set_cfg(0, 10, 10, 0, 0, 2'b00); upd = 1'b1; run(25);
        set_cfg(0, 10, 11, 0, 0, 2'b00); upd = 1'b1; run(25);
        // Center mode
        set_cfg(0, 4, 2, 4, 1, 2'b00); upd = 1'b1; run(20);
        // Prescaler and polarity, then idle level
        set_cfg(2, 4, 1, 0, 0, 2'b01); upd = 1'b1; run(30);
        en = 1'b0; run(4);
        en = 1'b1; run(15);
        // Mid-period shadowing with a second pulse near the boundary
        set_cfg(0, 10, 3, 0, 0, 2'b00); upd = 1'b1; run(15);
        set_cfg(0, 10, 7, 0, 0, 2'b00); upd = 1'b1; run(4);
        upd = 1'b1; run(1);
        upd = 1'b1; run(20);
        // Reset with an update pending
        set_cfg(20, 10, 5, 5, 0, 2'b10); upd = 1'b1; run(3);
        do_reset();
        run(10);
        upd = 1'b1; run(30);
        // Randomized configurations
        for (int it = 0; it < 50; it++) begin
            int mx;
            mx = $urandom_range(0, 12);
            set_cfg($urandom_range(0, 3), mx, $urandom_range(0, mx + 2), $urandom_range(0, mx + 2),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            upd = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
            end
            run($urandom_range(5, 40));
            if ($urandom_range(0, 3) == 0) begin
                psc = 8'($urandom_range(0, 2));
                run($urandom_range(1, 10));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reflet_pwm_multi.md
# reflet_pwm_multi

Multi-channel PWM generator, the parametrised successor of the single-channel `reflet_pwm_pwm`. One prescaled period counter is shared by `CHANNELS` compare channels. Each channel has its own duty cycle and output polarity. Configuration is double-buffered: software-side values load into active registers only at a period boundary, so outputs never glitch. The block sits behind the microcontroller's PWM peripheral register file, which drives the config inputs and pulses `update`.

## Interface
- `WIDTH`, 8: width of the period counter, `max` and each duty value.
- `CHANNELS`, 4: number of independent PWM outputs.
- `PRESCALER_WIDTH`, 8: width of the clock prescaler.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: runs counters when high.
- `prescaler` in `PRESCALER_WIDTH`: one counter tick every `prescaler+1` clk cycles. Not shadowed.
- `max` in `WIDTH`: period length (shadowed).
- `center_mode` in 1: 0 = edge-aligned, 1 = center-aligned (shadowed).
- `duty_cycle` in `CHANNELS*WIDTH`: channel n occupies bits `[n*WIDTH +: WIDTH]` (shadowed).
- `invert` in `CHANNELS`: per-channel output polarity. Applied combinationally before the output register. Not shadowed.
- `update` in 1: request to load shadowed inputs.
- `update_ack` out 1: one-cycle pulse when the active registers load.
- `period_start` out 1: one-cycle pulse at each period start.
- `out` out `CHANNELS`: registered PWM outputs.

## Operation
- **Prescaler**
  - `pre_cnt` increments each clk while enabled.
  - `tick` is asserted when `pre_cnt >= prescaler`. `pre_cnt` then returns to 0.
  - If `prescaler` is lowered below `pre_cnt`, the next cycle ticks.
- **Edge mode**
  - The counter runs 0..`max_a`-1 on ticks, then wraps to 0. Period = `max_a` ticks.
  - Channel raw level = `cnt < duty_a[n]`.
- **Center mode**
  - The counter counts up 0..`max_a`, then down to 1, then 0 again. Period = 2·`max_a` ticks.
  - Direction flips at `max_a` (to down) and at 1 (to up after reaching 0).
  - Raw level = `cnt < duty_a[n]`. High time is 2d-1 ticks for 0<d≤`max_a`, 0 for d=0, and the full period for d>`max_a`.
- **Boundary cases**
  - duty=0 gives constant low.
  - duty≥`max_a` gives constant high in edge mode.
  - `max_a`=0: counter held at 0, raw level = `duty_a[n] != 0`.
- **Output**
  - `out[n]` is registered `raw ^ invert[n]`.
  - While `enable`=0: `pre_cnt`, counter and direction are held at 0/up, and `out` = `invert` (idle level).
- **Shadow update**
  - `update` sets `pending`.
  - Active registers (`max_a`, `center_a`, `duty_a`) load from the inputs at the next period boundary, defined as the tick on which the counter returns to 0 (edge wrap, or center down-count reaching 0).
  - The load clears `pending` and pulses `update_ack`.
  - While `enable`=0, a pending or same-cycle update loads on the next clk edge.
  - `update` asserted in the same cycle as a boundary tick is honoured at that boundary, with inputs sampled that cycle.
  - `update` asserted while already pending is absorbed. The most recent input values at load time win.
  - Loading resets the counter to 0 and direction to up. This also applies when the mode changes.
- **Enable deassert mid-period**: counters clear immediately. Re-enable starts a fresh period with `period_start`.

## Timing
- **Reset values**: `out`=0, `update_ack`=0, `period_start`=0, `pre_cnt`=0, counter=0, direction=up, `max_a`=0, `duty_a`=0, `center_a`=0, `pending`=0.
  - First clk after reset release: `out` = `invert`, because the block is disabled or `max_a`=0 with duty 0.
- **Latency**: counter value c drives `out` on the following clk edge, a 1-cycle registered latency.
- **Period start**
  - `period_start` asserts in the cycle where `out` first reflects counter 0 of a new period.
  - It also asserts one cycle after `enable` rises.
- **Update acknowledge**
  - `update_ack` asserts the cycle after active registers load.
  - It coincides with `period_start` when enabled.
- **Reset mid-operation**: all state returns to reset values asynchronously. The pending update is lost.

## Test plan
- **Edge-mode duty**: `WIDTH`=8, `CHANNELS`=2, `prescaler`=0, `max`=10, duty {3,0}, edge, `update` while disabled, then `enable`.
  - ch0 is high 3 of every 10 cycles, starting with `period_start`.
  - ch1 stays low.
  - `update_ack` pulses once.
- **Duty at and above max**: ch0 duty=10, then duty=11, each loaded via `update`.
  - ch0 is constantly high in both cases.
  - The change appears only after the next `period_start`.
- **Center mode**: `max`=4, duty ch0=2, ch1=4.
  - Counter sequence 0,1,2,3,4,3,2,1 repeats.
  - ch0 is high 3 of 8 cycles, centred on counter 0.
  - ch1 is low only at counter 4.
- **Prescaler and polarity**: `prescaler`=2, `max`=4, duty=1, `invert`=01.
  - ch0 is low for 3 clk, then high for 9 clk, period 12.
  - `enable`=0 drives `out`=01.
- **Mid-period shadowing**: change duty 3→7 and pulse `update` at counter 5 (`max` 10).
  - The current period keeps duty 3.
  - Duty 7 applies from the next period.
  - `update_ack` and `period_start` pulse together.
  - A second `update` pulse at the boundary tick is consumed by that same load.
- **Reset mid-operation**: assert `reset` at counter 6 with `pending`=1.
  - `out`=0 and all pulses are 0 immediately.
  - After release with `enable`=1 and `max_a`=0, `out` = `invert` until a new `update`.
